// File: rtl/lsu_mem_if_pkg.sv
// lsu_mem_if_pkg: shared types for the load/store RAM initiator.
//   word_t   : data word of WORD_W bits
//   size_t   : request size encodings (byte, half, word, illegal)
//   state_t  : 2-bit FSM state encodings
//   misaligned(): access crosses a word boundary
package lsu_mem_if_pkg;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
   typedef enum logic [1:0] {
      SIZE_B   = 2'b00,
      SIZE_H   = 2'b01,
      SIZE_W   = 2'b10,
      SIZE_ILL = 2'b11
   } size_t;
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC0 = 2'b01,
      ST_ACC1 = 2'b10,
      ST_RESP = 2'b11
   } state_t;
   function automatic logic misaligned(size_t s, logic [1:0] off);
      return (s == SIZE_H && off == 2'd3) || (s == SIZE_W && off != 2'd0);
   endfunction
endpackage

// File: rtl/lsu_mem_if_if.sv
// lsu_mem_if_if: request/response and RAM-side signal bundle of the LSU.
//   req_*  : request from the memory stage (valid/ready handshake)
//   resp_* : one-cycle completion pulse with load data and error flag
//   mem_*  : single-port word RAM (combinational read, clocked write)
//   slave  : LSU view; master : core/RAM view
interface lsu_mem_if_if
   import lsu_mem_if_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [ADDR_W-1:0] req_addr_i;
   word_t             req_wdata_i;
   logic              resp_valid_o;
   word_t             resp_rdata_o;
   logic              resp_err_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_w_en_o;
   word_t             mem_w_data_o;
   logic [3:0]        mem_w_sel_o;
   word_t             mem_r_data_i;
   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_r_data_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
             mem_addr_o, mem_w_en_o, mem_w_data_o, mem_w_sel_o
   );
   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_r_data_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
             mem_addr_o, mem_w_en_o, mem_w_data_o, mem_w_sel_o
   );
endinterface

// File: rtl/lsu_mem_if_lane_align.sv
// lsu_lane_align: combinational little-endian lane steering.
//   i_off/i_size     : byte offset in word and access size
//   i_unsigned       : zero-extend (1) or sign-extend (0) loads
//   i_wdata          : right-justified store data
//   i_rbuf           : {buf1,buf0} captured read words
//   o_m8             : byte-lane mask across two words
//   o_d64            : store data shifted into lanes across two words
//   o_rdata          : extracted and extended load data
module lsu_lane_align
   import lsu_mem_if_pkg::*;
(
   input  logic [1:0]  i_off,
   input  size_t       i_size,
   input  logic        i_unsigned,
   input  word_t       i_wdata,
   input  logic [63:0] i_rbuf,
   output logic [7:0]  o_m8,
   output logic [63:0] o_d64,
   output word_t       o_rdata
);
   logic [3:0]  w_mask;
   logic [5:0]  w_bits;
   logic [63:0] w_sh;
   assign w_mask = i_size == SIZE_B ? 4'b0001 :
                   i_size == SIZE_H ? 4'b0011 :
                   i_size == SIZE_W ? 4'b1111 : 4'b0000;
   assign w_bits = {1'b0, i_off, 3'b000};
   assign o_m8   = {4'b0000, w_mask} << i_off;
   assign o_d64  = {32'b0, i_wdata} << w_bits;
   assign w_sh   = i_rbuf >> w_bits;
   assign o_rdata = i_size == SIZE_B ? {{24{~i_unsigned & w_sh[7]}}, w_sh[7:0]} :
                    i_size == SIZE_H ? {{16{~i_unsigned & w_sh[15]}}, w_sh[15:0]} :
                    w_sh[31:0];
endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store initiator driving a single-port word RAM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lsu_mem_if_if.slave (request, response and RAM signals)
// Optional: define MISALIGN_SPLIT_EN to split misaligned half/word
// accesses into two RAM accesses; otherwise they are rejected with err.
module lsu_mem_if
   import lsu_mem_if_pkg::*;
#(
   parameter int ADDR_W = 32
)(
   input logic         clk,
   input logic         rst,
   lsu_mem_if_if.slave bus
);
   state_t            r_state, w_next;
   logic              r_we, r_uns, r_err;
   size_t             r_size;
   logic [ADDR_W-1:0] r_addr;
   word_t             r_wdata, r_buf0;
   logic              w_accept, w_req_ill, w_mis, w_wr, w_hi;
   size_t             w_req_size;
   logic [ADDR_W-1:0] w_word_addr, w_next_addr;
   logic [63:0]       w_rbuf, w_d64;
   logic [7:0]        w_m8;
   word_t             w_rdata;
   assign w_accept    = bus.req_valid_i && r_state == ST_IDLE;
   assign w_req_size  = size_t'(bus.req_size_i);
   assign w_mis       = misaligned(r_size, r_addr[1:0]);
   assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};
   // second word of a split access; wraps at the top of the address space
   assign w_next_addr = {r_addr[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
`ifdef MISALIGN_SPLIT_EN
   word_t r_buf1;
   assign w_req_ill = w_req_size == SIZE_ILL;
   assign w_hi      = r_state == ST_ACC1;
   assign w_rbuf    = {r_buf1, r_buf0};
`else
   assign w_req_ill = w_req_size == SIZE_ILL || misaligned(w_req_size, bus.req_addr_i[1:0]);
   assign w_hi      = 1'b0;
   assign w_rbuf    = {32'b0, r_buf0};
`endif
   lsu_lane_align u_align (
      .i_off      (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .i_wdata    (r_wdata),
      .i_rbuf     (w_rbuf),
      .o_m8       (w_m8),
      .o_d64      (w_d64),
      .o_rdata    (w_rdata)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_IDLE: w_next = !w_accept ? ST_IDLE : w_req_ill ? ST_RESP : ST_ACC0;
`ifdef MISALIGN_SPLIT_EN
         ST_ACC0: w_next = w_mis ? ST_ACC1 : ST_RESP;
         ST_ACC1: w_next = ST_RESP;
`else
         ST_ACC0: w_next = ST_RESP;
`endif
         default: w_next = ST_IDLE;
      endcase
   end
   always_comb begin
      w_wr              = r_we && (r_state == ST_ACC0 || w_hi);
      bus.req_ready_o   = r_state == ST_IDLE;
      bus.resp_valid_o  = r_state == ST_RESP;
      bus.resp_err_o    = r_state == ST_RESP && r_err;
      bus.resp_rdata_o  = (r_state == ST_RESP && !r_err && !r_we) ? w_rdata : '0;
      bus.mem_addr_o    = r_state == ST_ACC0 ? w_word_addr : w_hi ? w_next_addr : '0;
      bus.mem_w_en_o    = w_wr;
      bus.mem_w_sel_o   = !w_wr ? 4'b0000 : w_hi ? w_m8[7:4] : w_m8[3:0];
      bus.mem_w_data_o  = !w_wr ? '0 : w_hi ? w_d64[63:32] : w_d64[31:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= SIZE_B;
         r_addr  <= '0;
         r_wdata <= '0;
         r_buf0  <= '0;
`ifdef MISALIGN_SPLIT_EN
         r_buf1  <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_we    <= bus.req_we_i;
            r_uns   <= bus.req_unsigned_i;
            r_err   <= w_req_ill;
            r_size  <= w_req_size;
            r_addr  <= bus.req_addr_i;
            r_wdata <= bus.req_wdata_i;
            r_buf0  <= '0;
`ifdef MISALIGN_SPLIT_EN
            r_buf1  <= '0;
`endif
         end
         if (r_state == ST_ACC0 && !r_we) r_buf0 <= bus.mem_r_data_i;
`ifdef MISALIGN_SPLIT_EN
         if (r_state == ST_ACC1 && !r_we) r_buf1 <= bus.mem_r_data_i;
`endif
      end
   end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed self-checking bench for lsu_mem_if with a small RAM.
module tb_lsu_mem_if;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [31:0] ram [0:63] = '{default: 32'h0};
   lsu_mem_if_if #(.ADDR_W(32)) bus ();
   lsu_mem_if #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // RAM: combinational read, byte-masked write on the clock edge
   assign bus.mem_r_data_i = ram[bus.mem_addr_o[7:2]];
   always @(posedge clk) begin
      for (int n = 0; n < 4; n++)
         if (bus.mem_w_en_o && bus.mem_w_sel_o[n]) ram[bus.mem_addr_o[7:2]][8*n +: 8] <= bus.mem_w_data_o[8*n +: 8];
   end
   // {ready, resp_valid, resp_err, w_en, w_sel}
   logic [7:0] ctl;
   assign ctl = {bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, bus.mem_w_en_o, bus.mem_w_sel_o};
   task automatic issue(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i = we;
      bus.req_size_i = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i = addr;
      bus.req_wdata_i = wdata;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      #1;
      total++;
      if (ctl !== 8'b1000_0000) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'b1000_0000); end
      total++;
      if ({bus.mem_addr_o, bus.mem_w_data_o, bus.resp_rdata_o} !== 96'h0) begin
         bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus.mem_addr_o, bus.mem_w_data_o, bus.resp_rdata_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();
      total++;
      if (ctl !== 8'b1000_0000) begin bad++; $display("FAIL reset_idle got=%b exp=%b", ctl, 8'b1000_0000); end
   endtask
   task automatic test_store_byte();
      issue(1'b1, 2'b00, 1'b0, 32'h6, 32'hAB);
      total++;
      if (ctl !== 8'b0001_0100) begin bad++; $display("FAIL sb_acc0_ctl got=%b exp=%b", ctl, 8'b0001_0100); end
      total++;
      if (bus.mem_addr_o !== 32'h4 || bus.mem_w_data_o !== 32'h00AB_0000) begin
         bad++; $display("FAIL sb_acc0_bus got=%h/%h exp=00000004/00ab0000", bus.mem_addr_o, bus.mem_w_data_o);
      end
      step();
      total++;
      if (ctl !== 8'b0100_0000 || bus.resp_rdata_o !== 32'h0) begin
         bad++; $display("FAIL sb_resp got=%b/%h exp=01000000/00000000", ctl, bus.resp_rdata_o);
      end
      step();
      total++;
      if (ctl !== 8'b1000_0000 || ram[1] !== 32'h00AB_0000) begin
         bad++; $display("FAIL sb_commit got=%b/%h exp=10000000/00ab0000", ctl, ram[1]);
      end
   endtask
   task automatic test_load_half();
      issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h8001_1234);
      step();
      step();
      total++;
      if (ram[0] !== 32'h8001_1234) begin bad++; $display("FAIL sw_commit got=%h exp=80011234", ram[0]); end
      issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
      total++;
      if (ctl !== 8'b0000_0000 || bus.mem_addr_o !== 32'h0) begin
         bad++; $display("FAIL lh_acc0 got=%b/%h exp=00000000/00000000", ctl, bus.mem_addr_o);
      end
      step();
      total++;
      if (bus.resp_rdata_o !== 32'hFFFF_8001 || ctl !== 8'b0100_0000) begin
         bad++; $display("FAIL lh_signed got=%h/%b exp=ffff8001/01000000", bus.resp_rdata_o, ctl);
      end
      step();
      issue(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
      step();
      total++;
      if (bus.resp_rdata_o !== 32'h0000_8001) begin bad++; $display("FAIL lhu got=%h exp=00008001", bus.resp_rdata_o); end
      step();
      issue(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
      step();
      total++;
      if (bus.resp_rdata_o !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_signed got=%h exp=ffffff80", bus.resp_rdata_o); end
      step();
      issue(1'b0, 2'b00, 1'b1, 32'h1, 32'h0);
      step();
      total++;
      if (bus.resp_rdata_o !== 32'h0000_0012) begin bad++; $display("FAIL lbu got=%h exp=00000012", bus.resp_rdata_o); end
      step();
   endtask
   task automatic test_back_to_back();
      issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
      step();
      step();
      issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      total++;
      if (ctl !== 8'b0000_0000 || bus.mem_addr_o !== 32'h8) begin
         bad++; $display("FAIL lw_acc0 got=%b/%h exp=00000000/00000008", ctl, bus.mem_addr_o);
      end
      step();
      total++;
      if (ctl !== 8'b0100_0000 || bus.resp_rdata_o !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL lw_resp got=%b/%h exp=01000000/deadbeef", ctl, bus.resp_rdata_o);
      end
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i = 1'b0;
      bus.req_size_i = 2'b10;
      bus.req_addr_i = 32'h8;
      step();
      total++;
      if (ctl !== 8'b1000_0000) begin bad++; $display("FAIL b2b_idle got=%b exp=10000000", ctl); end
      step();
      bus.req_valid_i = 1'b0;
      total++;
      if (ctl !== 8'b0000_0000 || bus.mem_addr_o !== 32'h8) begin
         bad++; $display("FAIL b2b_accept got=%b/%h exp=00000000/00000008", ctl, bus.mem_addr_o);
      end
      step();
      total++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL b2b_resp got=%b/%h exp=1/deadbeef", bus.resp_valid_o, bus.resp_rdata_o);
      end
      step();
   endtask
   task automatic test_illegal_size();
      issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
      total++;
      if (ctl !== 8'b0110_0000 || bus.resp_rdata_o !== 32'h0) begin
         bad++; $display("FAIL ill_load got=%b/%h exp=01100000/00000000", ctl, bus.resp_rdata_o);
      end
      step();
      issue(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF);
      total++;
      if (ctl !== 8'b0110_0000) begin bad++; $display("FAIL ill_store got=%b exp=01100000", ctl); end
      step();
      total++;
      if (ctl !== 8'b1000_0000 || ram[0] !== 32'h8001_1234) begin
         bad++; $display("FAIL ill_norite got=%b/%h exp=10000000/80011234", ctl, ram[0]);
      end
   endtask
`ifdef MISALIGN_SPLIT_EN
   task automatic test_split();
      issue(1'b1, 2'b10, 1'b0, 32'h5, 32'h4433_2211);
      total++;
      if (ctl !== 8'b0001_1110 || bus.mem_addr_o !== 32'h4 || bus.mem_w_data_o !== 32'h3322_1100) begin
         bad++; $display("FAIL ssw_acc0 got=%b/%h/%h exp=00011110/00000004/33221100", ctl, bus.mem_addr_o, bus.mem_w_data_o);
      end
      step();
      total++;
      if (ctl !== 8'b0001_0001 || bus.mem_addr_o !== 32'h8 || bus.mem_w_data_o !== 32'h0000_0044) begin
         bad++; $display("FAIL ssw_acc1 got=%b/%h/%h exp=00010001/00000008/00000044", ctl, bus.mem_addr_o, bus.mem_w_data_o);
      end
      step();
      total++;
      if (ctl !== 8'b0100_0000) begin bad++; $display("FAIL ssw_resp got=%b exp=01000000", ctl); end
      step();
      total++;
      if (ram[1] !== 32'h3322_1100 || ram[2] !== 32'hDEAD_BE44) begin
         bad++; $display("FAIL ssw_ram got=%h/%h exp=33221100/deadbe44", ram[1], ram[2]);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
      step();
      step();
      total++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== 32'h4433_2211) begin
         bad++; $display("FAIL slw got=%b/%h exp=1/44332211", bus.resp_valid_o, bus.resp_rdata_o);
      end
      step();
      issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0);
      total++;
      if (bus.mem_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_acc0 got=%h exp=fffffffc", bus.mem_addr_o); end
      step();
      total++;
      if (bus.mem_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_acc1 got=%h exp=00000000", bus.mem_addr_o); end
      step();
      total++;
      if (bus.resp_rdata_o !== 32'h0112_3400) begin bad++; $display("FAIL wrap_data got=%h exp=01123400", bus.resp_rdata_o); end
      step();
   endtask
   task automatic test_reset_mid();
      issue(1'b1, 2'b10, 1'b0, 32'h11, 32'hCCBB_AA99);
      step();
      rst = 1'b1;
      #1;
      total++;
      if (ctl !== 8'b1000_0000 || bus.mem_addr_o !== 32'h0 || bus.mem_w_data_o !== 32'h0) begin
         bad++; $display("FAIL rstmid_out got=%b/%h/%h exp=10000000/0/0", ctl, bus.mem_addr_o, bus.mem_w_data_o);
      end
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      step();
      total++;
      if (ctl !== 8'b1000_0000 || ram[4] !== 32'hBBAA_9900 || ram[5] !== 32'h0) begin
         bad++; $display("FAIL rstmid_ram got=%b/%h/%h exp=10000000/bbaa9900/00000000", ctl, ram[4], ram[5]);
      end
   endtask
`else
   task automatic test_misalign_err();
      issue(1'b0, 2'b10, 1'b0, 32'h5, 32'h0);
      total++;
      if (ctl !== 8'b0110_0000 || bus.resp_rdata_o !== 32'h0) begin
         bad++; $display("FAIL mis_lw got=%b/%h exp=01100000/00000000", ctl, bus.resp_rdata_o);
      end
      step();
      issue(1'b1, 2'b01, 1'b0, 32'h7, 32'h5555);
      total++;
      if (ctl !== 8'b0110_0000) begin bad++; $display("FAIL mis_sh got=%b exp=01100000", ctl); end
      step();
      total++;
      if (ctl !== 8'b1000_0000 || ram[1] !== 32'h00AB_0000) begin
         bad++; $display("FAIL mis_norite got=%b/%h exp=10000000/00ab0000", ctl, ram[1]);
      end
   endtask
   task automatic test_reset_mid();
      issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h5A);
      step();
      rst = 1'b1;
      #1;
      total++;
      if (ctl !== 8'b1000_0000 || bus.resp_rdata_o !== 32'h0) begin
         bad++; $display("FAIL rstmid_out got=%b/%h exp=10000000/00000000", ctl, bus.resp_rdata_o);
      end
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      step();
      total++;
      if (ctl !== 8'b1000_0000 || ram[4] !== 32'h0000_005A) begin
         bad++; $display("FAIL rstmid_ram got=%b/%h exp=10000000/0000005a", ctl, ram[4]);
      end
   endtask
`endif
   initial begin
      bus.req_valid_i = 1'b0;
      bus.req_we_i = 1'b0;
      bus.req_size_i = 2'b00;
      bus.req_unsigned_i = 1'b0;
      bus.req_addr_i = '0;
      bus.req_wdata_i = '0;
      test_reset();
      test_store_byte();
      test_load_half();
      test_back_to_back();
      test_illegal_size();
`ifdef MISALIGN_SPLIT_EN
      test_split();
`else
      test_misalign_err();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
